// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: sideband message codes, CAL responder state
// encoding and default timeout, common to the CAL initiator and responders.
package mbinit_pkg;

  localparam logic [3:0] MBINIT_CAL_Done_req  = 4'b0001;
  localparam logic [3:0] MBINIT_CAL_Done_resp = 4'b0010;

  localparam int TIMEOUT_CYCLES_DFLT = 800000;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_REQ  = 3'd1;
  localparam logic [2:0] ST_SEND_RESP = 3'd2;
  localparam logic [2:0] ST_WAIT_SENT = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_TIMEOUT   = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    WAIT_REQ  = ST_WAIT_REQ,
    SEND_RESP = ST_SEND_RESP,
    WAIT_SENT = ST_WAIT_SENT,
    DONE      = ST_DONE,
    TIMEOUT   = ST_TIMEOUT
  } cal_rsp_state_e;

endpackage

// File: rtl/mbinit_cal_responder_if.sv
// Sideband bundle between the CAL responder (master) and the shared
// sideband RX decoder / TX path (slave).
interface mbinit_cal_responder_if #(
  parameter int SB_MSG_WIDTH = 4
);
  logic                    i_Busy_SideBand;
  logic [SB_MSG_WIDTH-1:0] i_RX_SbMessage;
  logic                    i_msg_valid;
  logic [SB_MSG_WIDTH-1:0] o_TX_SbMessage;
  logic                    o_ValidOutDatat_Module;

  modport master (
    input  i_Busy_SideBand,
    input  i_RX_SbMessage,
    input  i_msg_valid,
    output o_TX_SbMessage,
    output o_ValidOutDatat_Module
  );

  modport slave (
    output i_Busy_SideBand,
    output i_RX_SbMessage,
    output i_msg_valid,
    input  o_TX_SbMessage,
    input  o_ValidOutDatat_Module
  );
endinterface

// File: rtl/mbinit_timeout_cnt.sv
// Up-counter with clear/enable; expire_o flags count == MAX-1 and the count
// holds there until cleared. Shared by the MBINIT responders.
module mbinit_timeout_cnt #(
  parameter int MAX = 16
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == W'(MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (en_i && !expire_o)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mbinit_cal_responder.sv
// MBINIT.CAL responder: answers Done_req with Done_resp over the sideband.
// Optional WAIT_REQ timeout enabled by macro MBINIT_CAL_RSP_TIMEOUT_EN.
module mbinit_cal_responder
  import mbinit_pkg::*;
#(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic                          i_MBINIT_PARAM_end,
  mbinit_cal_responder_if.master        sb,
  output logic                          o_MBINIT_CAL_resp_end,
  output logic                          o_cal_timeout
);
  cal_rsp_state_e state_q, state_d;
  logic req_pend_q, req_pend_d;
  logic done_seen_q, done_seen_d;
  logic valid_q, valid_d;
  logic [SB_MSG_WIDTH-1:0] tx_q, tx_d;
  logic resp_end_q, resp_end_d;
  logic req_now, req_any, en, busy;

  assign en      = i_MBINIT_PARAM_end;
  assign busy    = sb.i_Busy_SideBand;
  assign req_now = sb.i_msg_valid && (sb.i_RX_SbMessage == SB_MSG_WIDTH'(MBINIT_CAL_Done_req));
  assign req_any = req_now || req_pend_q;

`ifdef MBINIT_CAL_RSP_TIMEOUT_EN
  logic expire, tmo_q, tmo_d;

  mbinit_timeout_cnt #(.MAX(TIMEOUT_CYCLES)) u_timeout_cnt (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .clr_i    (state_q != WAIT_REQ),
    .en_i     (state_q == WAIT_REQ),
    .expire_o (expire)
  );
`endif

  always_comb begin
    state_d     = state_q;
    req_pend_d  = req_pend_q;
    done_seen_d = done_seen_q;
    case (state_q)
      IDLE:      if (en) state_d = WAIT_REQ;
      WAIT_REQ: begin
        if (!en)                  state_d = IDLE;
        else if (req_any && !busy) state_d = SEND_RESP;
`ifdef MBINIT_CAL_RSP_TIMEOUT_EN
        else if (expire && !req_any) state_d = TIMEOUT;
`endif
      end
      SEND_RESP: begin
        if (!en)       state_d = IDLE;
        else if (busy) state_d = WAIT_SENT;
      end
      WAIT_SENT: begin
        if (!en)        state_d = IDLE;
        else if (!busy) state_d = DONE;
      end
      DONE: begin
        if (!en)                   state_d = IDLE;
        else if (req_any && !busy) state_d = SEND_RESP;
      end
`ifdef MBINIT_CAL_RSP_TIMEOUT_EN
      TIMEOUT:   if (!en) state_d = IDLE;
`endif
      default:   state_d = IDLE;
    endcase

    // A request caught while not ready is remembered until the response goes out.
    if (!en)                                              req_pend_d = 1'b0;
    else if (state_d == SEND_RESP && state_q != SEND_RESP) req_pend_d = 1'b0;
    else if (req_now && state_q != SEND_RESP)             req_pend_d = 1'b1;

    if (state_d == IDLE)      done_seen_d = 1'b0;
    else if (state_d == DONE) done_seen_d = 1'b1;

    valid_d    = (state_d == SEND_RESP);
    tx_d       = valid_d ? SB_MSG_WIDTH'(MBINIT_CAL_Done_resp) : '0;
    resp_end_d = done_seen_d && (state_d inside {SEND_RESP, WAIT_SENT, DONE});
`ifdef MBINIT_CAL_RSP_TIMEOUT_EN
    tmo_d      = (state_d == TIMEOUT);
`endif
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_pend_q  <= 1'b0;
      done_seen_q <= 1'b0;
      valid_q     <= 1'b0;
      tx_q        <= '0;
      resp_end_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_pend_q  <= req_pend_d;
      done_seen_q <= done_seen_d;
      valid_q     <= valid_d;
      tx_q        <= tx_d;
      resp_end_q  <= resp_end_d;
    end
  end

`ifdef MBINIT_CAL_RSP_TIMEOUT_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) tmo_q <= 1'b0;
    else        tmo_q <= tmo_d;
  end
  assign o_cal_timeout = tmo_q;
`else
  assign o_cal_timeout = 1'b0;
`endif

  assign sb.o_ValidOutDatat_Module = valid_q;
  assign sb.o_TX_SbMessage         = tx_q;
  assign o_MBINIT_CAL_resp_end     = resp_end_q;
endmodule

// File: tb/tb_mbinit_cal_responder.sv
// Directed bench for mbinit_cal_responder; expected values hand-derived
// from the handshake timing (outputs land one clock after the cause).
module tb_mbinit_cal_responder;
  import mbinit_pkg::*;

  logic CLK = 1'b0;
  logic rst_n;
  logic en;
  logic resp_end;
  logic cal_tmo;
  int   total = 0;
  int   bad   = 0;

  mbinit_cal_responder_if #(.SB_MSG_WIDTH(4)) sb ();

  mbinit_cal_responder #(.SB_MSG_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
    .CLK                   (CLK),
    .rst_n                 (rst_n),
    .i_MBINIT_PARAM_end    (en),
    .sb                    (sb.master),
    .o_MBINIT_CAL_resp_end (resp_end),
    .o_cal_timeout         (cal_tmo)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] tx, input logic re);
    check({tag, "_valid"},    {31'd0, sb.o_ValidOutDatat_Module}, {31'd0, v});
    check({tag, "_tx"},       {28'd0, sb.o_TX_SbMessage},         {28'd0, tx});
    check({tag, "_resp_end"}, {31'd0, resp_end},                  {31'd0, re});
  endtask

  task automatic send_req(input logic [3:0] code);
    sb.i_msg_valid    = 1'b1;
    sb.i_RX_SbMessage = code;
  endtask

  task automatic clear_req();
    sb.i_msg_valid    = 1'b0;
    sb.i_RX_SbMessage = 4'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    sb.i_Busy_SideBand = 1'b0;
    clear_req();
    step(2);
    check_out("reset", 1'b0, 4'h0, 1'b0);
    check("reset_tmo", {31'd0, cal_tmo}, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic handshake
    en = 1'b1;
    step();
    check_out("t1_wait", 1'b0, 4'h0, 1'b0);
    send_req(4'b0001);
    step();
    clear_req();
    check_out("t1_send", 1'b1, 4'h2, 1'b0);
    step();
    check_out("t1_hold", 1'b1, 4'h2, 1'b0);
    sb.i_Busy_SideBand = 1'b1;
    step();
    check_out("t1_sent", 1'b0, 4'h0, 1'b0);
    step(2);
    check_out("t1_sent2", 1'b0, 4'h0, 1'b0);
    sb.i_Busy_SideBand = 1'b0;
    step();
    check_out("t1_done", 1'b0, 4'h0, 1'b1);

    // Non-request codes in DONE are ignored
    send_req(4'b0010);
    step();
    clear_req();
    check_out("ign_resp", 1'b0, 4'h0, 1'b1);
    send_req(4'b0111);
    step();
    clear_req();
    check_out("ign_other", 1'b0, 4'h0, 1'b1);

    // Partner retry in DONE
    send_req(4'b0001);
    step();
    clear_req();
    check_out("t4_resend", 1'b1, 4'h2, 1'b1);
    sb.i_Busy_SideBand = 1'b1;
    step();
    check_out("t4_sent", 1'b0, 4'h0, 1'b1);
    sb.i_Busy_SideBand = 1'b0;
    step();
    check_out("t4_done", 1'b0, 4'h0, 1'b1);

    // Retry in DONE while busy is deferred, then sent
    sb.i_Busy_SideBand = 1'b1;
    send_req(4'b0001);
    step();
    clear_req();
    check_out("t4_busy", 1'b0, 4'h0, 1'b1);
    sb.i_Busy_SideBand = 1'b0;
    step();
    check_out("t4_pend", 1'b1, 4'h2, 1'b1);

    // Enable drop with same-cycle request in SEND_RESP
    en = 1'b0;
    send_req(4'b0001);
    step();
    clear_req();
    check_out("t5_abort", 1'b0, 4'h0, 1'b0);
    en = 1'b1;
    step(2);
    check_out("t5_nopend", 1'b0, 4'h0, 1'b0);

    // Request while disabled is dropped
    en = 1'b0;
    step();
    send_req(4'b0001);
    step();
    clear_req();
    en = 1'b1;
    step(3);
    check_out("t2_dropped", 1'b0, 4'h0, 1'b0);

    // Request in IDLE with enable high is captured
    en = 1'b0;
    step();
    en = 1'b1;
    send_req(4'b0001);
    step();
    clear_req();
    check_out("t2_capture", 1'b0, 4'h0, 1'b0);
    step();
    check_out("t2_send", 1'b1, 4'h2, 1'b0);
    sb.i_Busy_SideBand = 1'b1;
    step();
    sb.i_Busy_SideBand = 1'b0;
    step();
    check_out("t2_done", 1'b0, 4'h0, 1'b1);

    // Request while busy defers response
    en = 1'b0;
    step();
    check_out("t3_idle", 1'b0, 4'h0, 1'b0);
    en = 1'b1;
    step();
    sb.i_Busy_SideBand = 1'b1;
    send_req(4'b0001);
    step();
    clear_req();
    for (int i = 0; i < 10; i++) begin
      check_out("t3_busy", 1'b0, 4'h0, 1'b0);
      step();
    end
    sb.i_Busy_SideBand = 1'b0;
    step();
    check_out("t3_send", 1'b1, 4'h2, 1'b0);

    // Async reset mid-response
    rst_n = 1'b0;
    #1;
    check_out("rst_mid", 1'b0, 4'h0, 1'b0);
    step();
    rst_n = 1'b1;

    // Timeout in WAIT_REQ (enable still high)
    step();
    step(15);
    check("t6_before", {31'd0, cal_tmo}, 32'd0);
    step();
`ifdef MBINIT_CAL_RSP_TIMEOUT_EN
    check("t6_timeout", {31'd0, cal_tmo}, 32'd1);
`else
    check("t6_timeout", {31'd0, cal_tmo}, 32'd0);
`endif
    check_out("t6_out", 1'b0, 4'h0, 1'b0);
    step(4);
    en = 1'b0;
    step();
    check("t6_clear", {31'd0, cal_tmo}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mbinit_cal_responder.md
Name: mbinit_cal_responder

Overview:
- Responder side of the MBINIT.CAL sideband handshake.
- Waits for the partner's MBINIT_CAL_Done_req (4'b0001) and answers with MBINIT_CAL_Done_resp (4'b0010) through the shared sideband TX path.
- Flags completion to the MBINIT controller, alongside the local CAL initiator.

Parameters:
- SB_MSG_WIDTH, 4, width of sideband message code
- TIMEOUT_CYCLES, 800000, WAIT_REQ cycles before timeout (used only with the optional feature)

Ports:
- CLK  in  1  clock
- rst_n  in  1  reset
- i_MBINIT_PARAM_end  in  1  enable; PARAM phase finished, CAL phase active while high
- i_Busy_SideBand  in  1  sideband TX busy
- i_RX_SbMessage  in  SB_MSG_WIDTH  decoded received message code
- i_msg_valid  in  1  i_RX_SbMessage valid this cycle
- o_TX_SbMessage  out  SB_MSG_WIDTH  message code to transmit
- o_ValidOutDatat_Module  out  1  TX request valid
- o_MBINIT_CAL_resp_end  out  1  response delivered
- o_cal_timeout  out  1  no request within timeout

Interface rule: reset rst_n, asynchronous, active-low; clock CLK.

Behaviour:
- Reset values: all outputs 0, state IDLE, req_pending 0, timeout counter 0.
- Outputs are registered and decoded from next state, so they appear one cycle after the causing input.
- req_pending:
  - Set on i_msg_valid && i_RX_SbMessage==4'b0001 in any state except SEND_RESP.
  - Cleared on entering SEND_RESP.
  - Cleared while !i_MBINIT_PARAM_end.
  - Captures a request that arrives before the responder is ready.
- States and transitions. In every non-IDLE state, !i_MBINIT_PARAM_end forces IDLE and takes priority over everything else, including a same-cycle request.
  - IDLE: on i_MBINIT_PARAM_end go to WAIT_REQ.
  - WAIT_REQ: go to SEND_RESP when a request is pending or arriving this cycle and !i_Busy_SideBand. A request seen while busy sets req_pending and the move is deferred.
  - SEND_RESP: o_ValidOutDatat_Module=1, o_TX_SbMessage=4'b0010. Held until i_Busy_SideBand=1, then go to WAIT_SENT.
  - WAIT_SENT: valid=0, TX code 0. On i_Busy_SideBand=0 go to DONE.
  - DONE: o_MBINIT_CAL_resp_end=1. A repeated request (partner retry) goes to SEND_RESP if !busy, otherwise sets req_pending and stays. o_MBINIT_CAL_resp_end stays 1 through a resend.
  - TIMEOUT (macro only): o_cal_timeout=1, all else 0. Left only via !i_MBINIT_PARAM_end.
  - Illegal encoding: go to IDLE.
- Messages other than 4'b0001, including 4'b0010, are ignored.
- Reset mid-operation: immediate return to reset values, with no residual valid pulse.

Optional Feature:
- Macro MBINIT_CAL_RSP_TIMEOUT_EN.
- Defined:
  - Counter width is $clog2(TIMEOUT_CYCLES).
  - The counter increments each cycle in WAIT_REQ and clears in any other state.
  - WAIT_REQ with count==TIMEOUT_CYCLES-1 and no request goes to TIMEOUT.
  - A request arriving in that same cycle wins.
- Undefined:
  - No counter and no TIMEOUT state.
  - o_cal_timeout tied to 0.
  - WAIT_REQ waits indefinitely.

Decomposition:
- Shared package mbinit_pkg holds:
  - Sideband codes MBINIT_CAL_Done_req=4'b0001 and MBINIT_CAL_Done_resp=4'b0010, shared with the initiator.
  - State encoding localparams.
  - Default TIMEOUT_CYCLES.
- Sub-module mbinit_timeout_cnt (clear/enable/expire) is shared with other MBINIT responders and instantiated only under the macro.

Test Plan:
1. Enable at cycle 2 (busy=0), request at cycle 5 → valid=1 with TX=4'b0010 at cycle 6; busy 1 at cycle 8 → valid=0 at cycle 9; busy 0 at cycle 12 → resp_end=1 at cycle 13.
2. Request while enable=0, then enable → req_pending cleared, no response. Request sent before enable but after reset, with enable already high → response sent.
3. Request with busy=1 for 10 cycles → valid stays 0; busy drops → valid=1 next cycle with TX=4'b0010.
4. In DONE, second request → valid=1 again while resp_end stays 1; full handshake completes back to DONE.
5. Enable drops during SEND_RESP in the same cycle a request arrives → next cycle all outputs 0, state IDLE.
6. With the macro and TIMEOUT_CYCLES=16, no request → o_cal_timeout=1 after 17 cycles in WAIT_REQ. Enable drop clears it. Without the macro it stays 0.
